// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants, types and helpers for the CLA add/sub pipe.
// Revision    : 1.0
// ============================================================================
package cla_pkg;

    localparam int c_BLOCK_2   = 2;
    localparam int c_BLOCK_4   = 4;
    localparam int c_BLOCK_8   = 8;
    localparam int c_BLOCK_MAX = c_BLOCK_8;

    typedef enum logic [1:0] {
        STG_ONE = 2'd1,
        STG_TWO = 2'd2
    } stages_e;

    typedef struct packed {
        logic p;
        logic g;
    } grp_pg_t;

    function automatic logic block_is_legal(input int blk);
        return (blk == c_BLOCK_2) || (blk == c_BLOCK_4) || (blk == c_BLOCK_8);
    endfunction

    // Group propagate/generate over the low n bits, written as flat sum-of-products.
    function automatic grp_pg_t group_pg(input logic [c_BLOCK_MAX-1:0] p,
                                         input logic [c_BLOCK_MAX-1:0] g,
                                         input int                     n);
        grp_pg_t r;
        logic    t;
        r.p = 1'b1;
        r.g = 1'b0;
        for (int i = 0; i < c_BLOCK_MAX; i++) begin
            if (i < n) begin
                r.p = r.p & p[i];
                t   = g[i];
                for (int j = i + 1; j < c_BLOCK_MAX; j++) begin
                    if (j < n) t = t & p[j];
                end
                r.g = r.g | t;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_group.sv
`default_nettype none
// ============================================================================
// Module      : cla_group
// Description : One BLOCK-bit lookahead group: per-bit carries and group P/G.
// Revision    : 1.0
// ============================================================================
module cla_group
    import cla_pkg::*;
#(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] p_i,
    input  logic [BLOCK-1:0] g_i,
    input  logic             cin_i,
    output logic [BLOCK-1:0] c_o,
    output grp_pg_t          pg_o
);

    logic w_term;

    // c_o[k] is the carry into bit k, expanded so no bit waits on its neighbour.
    always_comb begin
        c_o    = '0;
        w_term = 1'b0;
        for (int k = 0; k < BLOCK; k++) begin
            w_term = cin_i;
            for (int j = 0; j < k; j++) w_term = w_term & p_i[j];
            c_o[k] = w_term;
            for (int i = 0; i < k; i++) begin
                w_term = g_i[i];
                for (int j = i + 1; j < k; j++) w_term = w_term & p_i[j];
                c_o[k] = c_o[k] | w_term;
            end
        end
    end

    assign pg_o = group_pg(c_BLOCK_MAX'(p_i), c_BLOCK_MAX'(g_i), BLOCK);

endmodule
`default_nettype wire

// File: rtl/pipelined_cla_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cla_addsub
// Description : Valid/ready pipelined two-level carry-lookahead adder/subtractor.
// Revision    : 1.0
// ============================================================================
module pipelined_cla_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int c_NGRP = WIDTH / BLOCK;

    generate
        if (((WIDTH % BLOCK) != 0) || (WIDTH < 4) || (WIDTH > 64)) begin : g_bad_width
            $error("pipelined_cla_addsub: WIDTH must be 4..64 and a multiple of BLOCK");
        end
        if (!block_is_legal(BLOCK)) begin : g_bad_block
            $error("pipelined_cla_addsub: BLOCK must be 2, 4 or 8");
        end
        if ((STAGES != int'(STG_ONE)) && (STAGES != int'(STG_TWO))) begin : g_bad_stages
            $error("pipelined_cla_addsub: STAGES must be 1 or 2");
        end
    endgenerate

    logic                 w_adv;
    logic [WIDTH-1:0]     w_bx;
    logic [WIDTH-1:0]     w_p_in;
    logic [WIDTH-1:0]     w_g_in;
    logic                 w_cv;
    logic [WIDTH-1:0]     w_cp;
    logic [WIDTH-1:0]     w_cg;
    logic                 w_ccin;
    grp_pg_t [c_NGRP-1:0] w_cgpg;
    grp_pg_t [c_NGRP-1:0] w_ipg;
    logic [c_NGRP:0]      w_gc;
    logic [WIDTH-1:0]     w_bc;
    logic [WIDTH-1:0]     w_sum_d;
    logic                 w_cout_d;
    logic                 w_ovf_d;
    logic                 w_zero_d;

    logic                 r_out_valid_q;
    logic [WIDTH-1:0]     r_result_q;
    logic                 r_cout_q;
    logic                 r_ovf_q;
    logic                 r_zero_q;

    assign w_adv    = rst | ~r_out_valid_q | out_ready;
    assign in_ready = w_adv;

    assign w_bx   = sub ? ~b : b;
    assign w_p_in = a ^ w_bx;
    assign w_g_in = a & w_bx;

    generate
        if (STAGES == int'(STG_TWO)) begin : g_two_stage
            grp_pg_t [c_NGRP-1:0] w_gpg_d;
            grp_pg_t [c_NGRP-1:0] r_gpg_q;
            logic                 r_s1_valid_q;
            logic [WIDTH-1:0]     r_p_q;
            logic [WIDTH-1:0]     r_g_q;
            logic                 r_cin_q;
            logic                 w_unused_ipg;

            for (genvar j = 0; j < c_NGRP; j++) begin : g_grp_pg
                assign w_gpg_d[j] = group_pg(c_BLOCK_MAX'(w_p_in[j*BLOCK +: BLOCK]),
                                             c_BLOCK_MAX'(w_g_in[j*BLOCK +: BLOCK]), BLOCK);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1_valid_q <= 1'b0;
                    r_p_q        <= '0;
                    r_g_q        <= '0;
                    r_cin_q      <= 1'b0;
                    r_gpg_q      <= '0;
                end else if (w_adv) begin
                    r_s1_valid_q <= in_valid;
                    if (in_valid) begin
                        r_p_q   <= w_p_in;
                        r_g_q   <= w_g_in;
                        r_cin_q <= cin;
                        r_gpg_q <= w_gpg_d;
                    end
                end
            end

            assign w_cv   = r_s1_valid_q;
            assign w_cp   = r_p_q;
            assign w_cg   = r_g_q;
            assign w_ccin = r_cin_q;
            // Group P/G already captured in stage 1; the instances' copies are redundant here.
            assign w_cgpg       = r_gpg_q;
            assign w_unused_ipg = ^w_ipg;
        end else begin : g_one_stage
            assign w_cv   = in_valid;
            assign w_cp   = w_p_in;
            assign w_cg   = w_g_in;
            assign w_ccin = cin;
            assign w_cgpg = w_ipg;
        end
    endgenerate

    always_comb begin
        w_gc    = '0;
        w_gc[0] = w_ccin;
        for (int j = 0; j < c_NGRP; j++) begin
            w_gc[j+1] = w_cgpg[j].g | (w_cgpg[j].p & w_gc[j]);
        end
    end

    generate
        for (genvar j = 0; j < c_NGRP; j++) begin : g_grp
            cla_group #(
                .BLOCK (BLOCK)
            ) u_cla_group (
                .p_i   (w_cp[j*BLOCK +: BLOCK]),
                .g_i   (w_cg[j*BLOCK +: BLOCK]),
                .cin_i (w_gc[j]),
                .c_o   (w_bc[j*BLOCK +: BLOCK]),
                .pg_o  (w_ipg[j])
            );
        end
    endgenerate

    assign w_sum_d  = w_cp ^ w_bc;
    assign w_cout_d = w_gc[c_NGRP];
    assign w_ovf_d  = w_bc[WIDTH-1] ^ w_gc[c_NGRP];
    assign w_zero_d = (w_sum_d == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid_q <= 1'b0;
            r_result_q    <= '0;
            r_cout_q      <= 1'b0;
            r_ovf_q       <= 1'b0;
            r_zero_q      <= 1'b0;
        end else if (w_adv) begin
            r_out_valid_q <= w_cv;
            if (w_cv) begin
                r_result_q <= w_sum_d;
                r_cout_q   <= w_cout_d;
                r_ovf_q    <= w_ovf_d;
                r_zero_q   <= w_zero_d;
            end
        end
    end

    assign out_valid = r_out_valid_q;
    assign result    = r_result_q;
    assign cout      = r_cout_q;
    assign ovf       = r_ovf_q;
    assign zero      = r_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_cla_addsub
// Description : Self-checking bench for pipelined_cla_addsub (32-bit, BLOCK 4, 2 stages).
// Revision    : 1.0
// ============================================================================
module tb_pipelined_cla_addsub;

    typedef struct packed {
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic        cin;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;

    int   n_pass;
    int   n_total;
    int   n_out;
    int   bp_snap;
    bit   bp_acc;
    exp_t q[$];
    vec_t vecs[10];

    pipelined_cla_addsub #(
        .WIDTH  (32),
        .BLOCK  (4),
        .STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: plain wide arithmetic on A + (sub ? ~B : B) + cin.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic ms, input logic mc);
        exp_t        m;
        logic [31:0] bb;
        logic [32:0] t;
        bb     = ms ? ~mb : mb;
        t      = {1'b0, ma} + {1'b0, bb} + {32'd0, mc};
        m.res  = t[31:0];
        m.cout = t[32];
        m.ovf  = (ma[31] == bb[31]) && (t[31] != ma[31]);
        m.zero = (t[31:0] == 32'd0);
        return m;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("out_without_input", 64'(out_valid), 64'd0);
                end else begin
                    chk("stream_result", 64'(result), 64'(q[0].res));
                    chk("stream_cout",   64'(cout),   64'(q[0].cout));
                    chk("stream_ovf",    64'(ovf),    64'(q[0].ovf));
                    chk("stream_zero",   64'(zero),   64'(q[0].zero));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) q.push_back(model(a, b, sub, cin));
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t m;
        @(posedge clk); #1;
        a = v.a; b = v.b; sub = v.sub; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("vec_not_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("vec_valid",  64'(out_valid), 64'd1);
        chk("vec_result", 64'(result),    64'(v.res));
        chk("vec_cout",   64'(cout),      64'(v.cout));
        chk("vec_ovf",    64'(ovf),       64'(v.ovf));
        chk("vec_zero",   64'(zero),      64'(v.zero));
        m = model(v.a, v.b, v.sub, v.cin);
        chk("model_result", 64'(m.res), 64'(v.res));
        chk("model_flags",  64'({m.cout, m.ovf, m.zero}), 64'({v.cout, v.ovf, v.zero}));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (((q.size() != 0) || out_valid) && (k < 50)) begin
            @(posedge clk); #1;
            k++;
        end
        chk(name, 64'(q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not terminate");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass = 0; n_total = 0; n_out = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;

        vecs[0] = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h5,         32'h7,         1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h7,         32'h5,         1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h1,         1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{32'hA,         32'h3,         1'b1, 1'b0, 32'h0000_0006, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{32'h0,         32'h0,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("in_ready_during_rst", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    64'(result),    64'd0);
        chk("rst_flags",     64'({cout, ovf, zero}), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Four back-to-back ops with the consumer stalling for three cycles.
        @(posedge clk); #1;
        bp_snap = n_out;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    a = 32'(i + 1); b = 32'(i + 1); sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
                    bp_acc = 1'b0;
                    for (int k = 0; (k < 20) && !bp_acc; k++) begin
                        @(negedge clk);
                        bp_acc = in_ready;
                        @(posedge clk); #1;
                    end
                    if (!bp_acc) chk("bp_accept_timeout", 64'd0, 64'd1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_held_valid",  64'(out_valid), 64'd1);
                    chk("bp_in_ready",    64'(in_ready),  64'd0);
                    chk("bp_held_result", 64'(result),    64'd2);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        chk("bp_delivered", 64'(n_out - bp_snap), 64'd4);

        // Reset with two operations in flight.
        @(posedge clk); #1;
        a = 32'h100; b = 32'h1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 32'h200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready_during", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_result",    64'(result),    64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd1);
        run_vec(vecs[4]);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a   = pick();
            b   = pick();
            sub = 1'($urandom_range(0, 1));
            cin = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        drain("rand_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_cla_addsub.md
PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter WIDTH, 32, operand/result width; SHALL be a multiple of BLOCK, 4..64.
REQ-002 Parameter BLOCK, 4, lookahead group size in bits; legal values 2, 4, 8.
REQ-003 Parameter STAGES, 2, pipeline depth: 1 = single output register; 2 = extra register after group P/G generation.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operands present.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in (add) / extra borrow-complement (sub).
REQ-011 sub  input  1  0 = A+B+cin, 1 = A+~B+cin (two's-complement subtract when cin=1).
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-015 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-016 ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-017 zero  output  1  result == 0.

Function
REQ-018 Pipeline SHALL advance (adv) when out_valid==0 or out_ready==1; in_ready SHALL equal adv, combinationally.
REQ-019 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-020 Latency SHALL be exactly STAGES cycles from input transfer to out_valid, absent backpressure; throughput one op/cycle.
REQ-021 Each stage holds a valid bit; on adv, stage k takes stage k-1 contents, stage 1 takes in_valid and operands; on !adv all stages SHALL hold unchanged.
REQ-022 Bubbles SHALL propagate as invalid stages; no bubble collapsing required.
REQ-023 Carries SHALL be computed by two-level lookahead: per-group P/G from BLOCK-bit groups, then group carries c[j+1] = G[j] | P[j]&c[j], c[0] = cin; no ripple across groups.
REQ-024 STAGES=2: stage 1 registers B' = sub ? ~b : b, A, cin, per-bit p/g and group P/G; stage 2 computes carries, result and flags.
REQ-025 result, cout, ovf, zero SHALL be registered and remain stable while out_valid & !out_ready.
REQ-026 When out_valid==0, result/flags values are don't-care but SHALL not be X after reset (zero-initialised).
REQ-027 Simultaneous transfer in and out SHALL be lossless; full pipeline with out_ready=1 sustains 1 op/cycle.
REQ-028 Wrap-around: A+B >= 2^WIDTH SHALL yield truncated result with cout=1.

Reset
REQ-029 On rst=1 at clk edge: all valid bits 0, result 0, cout 0, ovf 0, zero 0; in-flight operations discarded.
REQ-030 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-031 rst mid-operation SHALL drop all pending results; no out_valid earlier than STAGES cycles after first post-reset transfer.

Structure
REQ-032 Shared package cla_pkg SHALL hold: BLOCK legal-value constants, the STAGES enumeration, and a typedef for the group P/G pair.
REQ-033 One sub-module cla_group SHALL implement a BLOCK-bit group: inputs p, g, group cin; outputs per-bit carries, group P, group G; instantiated WIDTH/BLOCK times.
REQ-034 Elaboration SHALL fail on WIDTH % BLOCK != 0 or STAGES outside {1,2}.

Verification (WIDTH=32, BLOCK=4, STAGES=2, out_ready=1 unless stated)
REQ-035 a=0xFFFFFFFF, b=1, sub=0, cin=0 -> 2 cycles later result=0, cout=1, ovf=0, zero=1.
REQ-036 a=0x7FFFFFFF, b=1, add -> result=0x80000000, cout=0, ovf=1, zero=0.
REQ-037 a=5, b=7, sub=1, cin=1 -> result=0xFFFFFFFE, cout=0, ovf=0; a=7, b=5 -> result=2, cout=1.
REQ-038 Stream 4 ops, out_ready=0 from cycle 2 for 3 cycles -> in_ready=0 while out_valid held, result unchanged, all 4 results delivered in order, none lost/duplicated.
REQ-039 Assert rst with 2 ops in flight -> next cycle out_valid=0, result=0, in_ready=1; fresh op returns after exactly 2 cycles.
REQ-040 10^5 random ops each config (STAGES 1/2, BLOCK 2/4/8, WIDTH 8/32/64), random valid/ready -> matches reference model (A + (sub?~B:B) + cin) for result, cout, ovf, zero.
